// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO in front of the VGA colour stage: buffers RGB332 pixels, locks the
// producer's start-of-frame to the display frame_start, flags underflow/misalignment.
module vga_pixel_fifo #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              app_clk,
    input  logic              app_arst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_sof,
    input  logic              frame_start,
    input  logic              de,
    input  logic              clr_flags,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              underflow,
    output logic              misalign,
    output logic [ADDR_W:0]   level
);

    typedef enum logic [1:0] {HUNT, ARMED, STREAM} state_t;

    localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_LVL  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

    logic [8:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q, level_d;
    state_t            state_q, state_d;
    logic              first_pix_q, first_pix_d;
    logic [7:0]        pix_q, pix_d;
    logic              underflow_q, underflow_d;
    logic              misalign_q, misalign_d;

    logic       push, pop, empty, head_sof, behind, set_uf, set_ma;
    logic [7:0] head_data;

    assign s_ready   = (level_q < FULL_LVL);
    assign push      = s_valid & s_ready;
    assign empty     = (level_q == '0);
    assign head_sof  = mem_q[rd_ptr_q][8];
    assign head_data = mem_q[rd_ptr_q][7:0];
    // Producer still mid-frame when the display starts a new one.
    assign behind    = !first_pix_q && !empty && !head_sof;

    always_ff @(posedge app_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_sof, s_data};
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + ONE_LVL;
            2'b01:   level_d = level_q - ONE_LVL;
            default: level_d = level_q;
        endcase
    end

    assign underflow_d = set_uf ? 1'b1 : (clr_flags ? 1'b0 : underflow_q);
    assign misalign_d  = set_ma ? 1'b1 : (clr_flags ? 1'b0 : misalign_q);

    always_ff @(posedge app_clk or negedge app_arst_n) begin
        if (!app_arst_n) begin
            state_q     <= HUNT;
            first_pix_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pix_q       <= '0;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_pix_q <= first_pix_d;
            if (push) wr_ptr_q <= wr_ptr_q + ONE_PTR;
            if (pop)  rd_ptr_q <= rd_ptr_q + ONE_PTR;
            level_q     <= level_d;
            pix_q       <= pix_d;
            underflow_q <= underflow_d;
            misalign_q  <= misalign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:  if (!empty && head_sof) state_d = ARMED;
            ARMED: if (frame_start) state_d = STREAM;
            STREAM: begin
                if (frame_start) begin
                    if (behind) state_d = HUNT;
                end else if (de) begin
                    if (empty)                          state_d = HUNT;
                    else if (head_sof && !first_pix_q)  state_d = ARMED;
                    else if (!head_sof && first_pix_q)  state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        pix_d       = '0;
        set_uf      = 1'b0;
        set_ma      = 1'b0;
        first_pix_d = first_pix_q;
        case (state_q)
            HUNT:  pop = !empty && !head_sof;
            ARMED: if (frame_start) first_pix_d = 1'b1;
            STREAM: begin
                // frame_start outranks de; the two never coincide in normal timing.
                if (frame_start) begin
                    if (behind) set_ma = 1'b1;
                    else        first_pix_d = 1'b1;
                end else if (de) begin
                    if (empty) begin
                        set_uf = 1'b1;
                    end else if (head_sof == first_pix_q) begin
                        pop         = 1'b1;
                        pix_d       = head_data;
                        first_pix_d = 1'b0;
                    end else begin
                        set_ma = 1'b1;
                    end
                end
            end
            default: pop = 1'b0;
        endcase
    end

    assign red       = pix_q[7:5];
    assign green     = pix_q[4:2];
    assign blue      = pix_q[1:0];
    assign underflow = underflow_q;
    assign misalign  = misalign_q;
    assign level     = level_q;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Scoreboard bench for vga_pixel_fifo: directed frames, expected pixels queued per de cycle.
module tb_vga_pixel_fifo;

    logic       app_clk = 1'b0;
    logic       app_arst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_sof = 1'b0;
    logic       frame_start = 1'b0;
    logic       de = 1'b0;
    logic       clr_flags = 1'b0;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       underflow, misalign;
    logic [4:0] level;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];
    logic       de_smp;

    vga_pixel_fifo #(.ADDR_W(4), .DEPTH(16)) dut (
        .app_clk(app_clk), .app_arst_n(app_arst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
        .frame_start(frame_start), .de(de), .clr_flags(clr_flags),
        .red(red), .green(green), .blue(blue),
        .underflow(underflow), .misalign(misalign), .level(level)
    );

    always #5 app_clk = ~app_clk;

    always @(posedge app_clk or negedge app_arst_n) begin
        if (!app_arst_n) de_smp <= 1'b0;
        else             de_smp <= de;
    end

    // Each sampled de produces exactly one registered pixel, checked half a cycle later.
    always @(negedge app_clk) begin
        if (de_smp) begin
            logic [7:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pixel: got %02h, required none (no expectation queued)", {red, green, blue});
            end else begin
                e = exp_q.pop_front();
                if ({red, green, blue} !== e) begin
                    n_err++;
                    $display("FAIL pixel: got %02h, required %02h", {red, green, blue}, e);
                end else begin
                    $display("pixel ok %02h", e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end else begin
            $display("check ok %s = %0h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge app_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_pix(input logic sof, input logic [7:0] d);
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic de_cycle(input logic [7:0] e);
        de = 1'b1;
        exp_q.push_back(e);
        tick();
        de = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_level", 16'(level), 16'h0);
        chk("rst_rgb", 16'({red, green, blue}), 16'h0);
        chk("rst_underflow", 16'(underflow), 16'h0);
        chk("rst_misalign", 16'(misalign), 16'h0);
        chk("rst_s_ready", 16'(s_ready), 16'h1);
        #10 app_arst_n = 1'b1;
        idle(2);

        // Lock-in: three stale pixels dropped, frame 01..0A streamed
        push_pix(1'b0, 8'hA1);
        push_pix(1'b0, 8'hA2);
        push_pix(1'b0, 8'hA3);
        for (int i = 1; i <= 10; i++) push_pix(i == 1, 8'(i));
        idle(3);
        chk("lock_level_armed", 16'(level), 16'd10);
        pulse_fs();
        for (int i = 1; i <= 10; i++) de_cycle(8'(i));
        idle(1);
        chk("lock_level_end", 16'(level), 16'd0);
        chk("lock_underflow", 16'(underflow), 16'h0);
        chk("lock_misalign", 16'(misalign), 16'h0);

        // Underflow: 4-pixel frame, then de with FIFO empty
        push_pix(1'b1, 8'h11);
        push_pix(1'b0, 8'h12);
        push_pix(1'b0, 8'h13);
        push_pix(1'b0, 8'h14);
        idle(1);
        pulse_fs();
        de_cycle(8'h11);
        de_cycle(8'h12);
        de_cycle(8'h13);
        de_cycle(8'h14);
        de_cycle(8'h00);
        chk("uf_set", 16'(underflow), 16'h1);
        chk("uf_no_misalign", 16'(misalign), 16'h0);
        pulse_clr();
        chk("uf_cleared", 16'(underflow), 16'h0);

        // Full / backpressure
        for (int i = 0; i < 16; i++) push_pix(i == 0, 8'(8'h20 + i));
        chk("full_level", 16'(level), 16'd16);
        chk("full_s_ready", 16'(s_ready), 16'h0);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_sof   = 1'b0;
        pulse_fs();
        de_cycle(8'h20);
        chk("bp_level_after_pop", 16'(level), 16'd15);
        chk("bp_s_ready_after_pop", 16'(s_ready), 16'h1);
        s_valid = 1'b0;
        for (int i = 1; i < 16; i++) de_cycle(8'(8'h20 + i));
        idle(1);
        chk("bp_drained", 16'(level), 16'd0);

        // Producer ahead: 5-pixel frame then the next sof
        push_pix(1'b1, 8'h31);
        for (int i = 2; i <= 5; i++) push_pix(1'b0, 8'(8'h30 + i));
        push_pix(1'b1, 8'h41);
        idle(2);
        chk("ahead_level_pre", 16'(level), 16'd6);
        pulse_fs();
        for (int i = 1; i <= 5; i++) de_cycle(8'(8'h30 + i));
        de_cycle(8'h00);
        chk("ahead_misalign", 16'(misalign), 16'h1);
        chk("ahead_level", 16'(level), 16'd1);
        chk("ahead_underflow", 16'(underflow), 16'h0);
        de_cycle(8'h00);
        chk("ahead_armed_hold", 16'(level), 16'd1);

        // Producer behind: frame_start while head is mid-frame
        pulse_clr();
        chk("behind_clr", 16'(misalign), 16'h0);
        pulse_fs();
        push_pix(1'b0, 8'h42);
        push_pix(1'b0, 8'h43);
        de_cycle(8'h41);
        de_cycle(8'h42);
        chk("behind_level_pre", 16'(level), 16'd1);
        pulse_fs();
        chk("behind_misalign", 16'(misalign), 16'h1);
        push_pix(1'b0, 8'h44);
        push_pix(1'b1, 8'h51);
        push_pix(1'b0, 8'h52);
        idle(3);
        chk("behind_hunt_level", 16'(level), 16'd2);

        // Reset mid-operation with level 7 while streaming
        pulse_fs();
        for (int i = 3; i <= 8; i++) push_pix(1'b0, 8'(8'h50 + i));
        de_cycle(8'h51);
        chk("mid_level_pre", 16'(level), 16'd7);
        @(negedge app_clk);
        #1 app_arst_n = 1'b0;
        #1;
        chk("mid_rst_level", 16'(level), 16'h0);
        chk("mid_rst_rgb", 16'({red, green, blue}), 16'h0);
        chk("mid_rst_underflow", 16'(underflow), 16'h0);
        chk("mid_rst_misalign", 16'(misalign), 16'h0);
        idle(2);
        @(negedge app_clk);
        app_arst_n = 1'b1;
        tick();
        chk("post_rst_s_ready", 16'(s_ready), 16'h1);
        push_pix(1'b0, 8'h61);
        push_pix(1'b0, 8'h62);
        idle(3);
        chk("post_rst_hunt_discard", 16'(level), 16'd0);
        push_pix(1'b1, 8'h71);
        idle(2);
        chk("post_rst_armed", 16'(level), 16'd1);
        pulse_fs();
        de_cycle(8'h71);
        idle(2);
        chk("end_queue_empty", 16'(exp_q.size()), 16'd0);
        chk("end_flags", 16'({underflow, misalign}), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
